// File: rtl/axppa_error_monitor_pkg.sv
// Shared definitions for the approximate-adder error monitor.
//   WIDTH_DEF    - default adder operand width (sums carry one extra bit)
//   CNT_W_DEF    - default sample-counter width
//   DRAIN_CYCLES - cycles spent flushing the two-stage datapath after the
//                  last sample of a window
//   state_t      - monitor control states
package axppa_err_pkg;

    localparam int WIDTH_DEF    = 16;
    localparam int CNT_W_DEF    = 20;
    localparam int DRAIN_CYCLES = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/axppa_error_monitor_if.sv
// Sample stream between the adder pair under test and the error monitor.
//   in_valid   - a sample pair is present on exact_sum/approx_sum
//   in_ready   - monitor is in its collection phase and takes the pair
//   exact_sum  - exact adder result, WIDTH+1 bits including carry-out
//   approx_sum - approximate adder result for the same operands
// master: the side producing sums; slave: the monitor.
interface axppa_error_monitor_if
    import axppa_err_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH:0]   exact_sum;
    logic [WIDTH:0]   approx_sum;

    modport master (
        output in_valid,
        output exact_sum,
        output approx_sum,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  exact_sum,
        input  approx_sum,
        output in_ready
    );

endinterface

// File: rtl/axppa_error_monitor_abs_diff.sv
// Combinational absolute difference of two WIDTH+1-bit sums.
//   a, b    - unsigned operands
//   ed      - |a - b|
//   nonzero - high when a differs from b
module axppa_abs_diff
    import axppa_err_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH:0] a,
    input  logic [WIDTH:0] b,
    output logic [WIDTH:0] ed,
    output logic           nonzero
);

    logic [WIDTH+1:0] a_minus_b;
    logic [WIDTH:0]   b_minus_a;

    // The extra top bit of a_minus_b is the borrow: when set, b is larger
    // and the reversed subtraction already fits in WIDTH+1 bits.
    assign a_minus_b = {1'b0, a} - {1'b0, b};
    assign b_minus_a = b - a;
    assign ed        = a_minus_b[WIDTH+1] ? b_minus_a : a_minus_b[WIDTH:0];
    assign nonzero   = (a != b);

endmodule

// File: rtl/axppa_error_monitor.sv
// Error-metric accumulator for approximate parallel-prefix adders.
// Over a window of accepted sample pairs it accumulates the error count,
// the sum of error distances and the maximum error distance, then pulses
// done for one cycle. Results hold until the next accepted start.
// Ports:
//   clk, rst     - clock and synchronous active-high reset
//   start        - begin a window (only honoured in IDLE)
//   window       - samples per window, latched with start; 0 finishes at once
//   smp          - sample stream (in_valid/in_ready/exact_sum/approx_sum)
//   busy         - high while collecting or draining
//   done         - one-cycle pulse when results are final
//   err_count    - samples whose sums differ
//   ed_sum       - sum of |exact - approx|
//   max_ed       - largest |exact - approx|
//   sample_count - samples accepted in the current/last window
//   sq_sum       - sum of squared error distances (only with
//                  AXPPA_ERR_MON_SQ_EN defined)
module axppa_error_monitor
    import axppa_err_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int ACC_W = WIDTH + 1 + CNT_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [CNT_W-1:0]    window,
    axppa_error_monitor_if.slave smp,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    err_count,
    output logic [ACC_W-1:0]    ed_sum,
    output logic [WIDTH:0]      max_ed,
`ifdef AXPPA_ERR_MON_SQ_EN
    output logic [2*(WIDTH+1)+CNT_W-1:0] sq_sum,
`endif
    output logic [CNT_W-1:0]    sample_count
);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] window_q;
    logic [1:0]       drain_cnt;
    logic             in_ready;
    logic             start_ok;
    logic             accept;
    logic             last_accept;

    logic [WIDTH:0]   ed_comb;
    logic             nz_comb;
    logic             s1_valid;
    logic [WIDTH:0]   s1_ed;
    logic             s1_nz;

    // Acceptance depends only on the state register, keeping the
    // next-state logic free of combinational feedback.
    assign start_ok    = (state == IDLE) && start;
    assign accept      = smp.in_valid && (state == RUN);
    assign last_accept = accept && ((sample_count + CNT_W'(1)) == window_q);
    assign smp.in_ready = in_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Counts cycles spent in DRAIN; restarts whenever DRAIN is left.
    always_ff @(posedge clk) begin
        if (rst || (state != DRAIN)) begin
            drain_cnt <= '0;
        end else begin
            drain_cnt <= drain_cnt + 2'd1;
        end
    end

    // Next-state and status outputs.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (window == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (last_accept) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (drain_cnt == 2'(DRAIN_CYCLES - 1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    axppa_abs_diff #(
        .WIDTH   (WIDTH)
    ) u_abs_diff (
        .a       (smp.exact_sum),
        .b       (smp.approx_sum),
        .ed      (ed_comb),
        .nonzero (nz_comb)
    );

    // Stage 1: register the error distance of each accepted pair.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_ed    <= '0;
            s1_nz    <= 1'b0;
        end else begin
            s1_valid <= accept;
            s1_ed    <= ed_comb;
            s1_nz    <= nz_comb;
        end
    end

    // Stage 2 accumulators plus window bookkeeping. A start in IDLE clears
    // everything; the pipeline is empty then, so it never races an update.
    always_ff @(posedge clk) begin
        if (rst) begin
            window_q     <= '0;
            sample_count <= '0;
            err_count    <= '0;
            ed_sum       <= '0;
            max_ed       <= '0;
        end else if (start_ok) begin
            window_q     <= window;
            sample_count <= '0;
            err_count    <= '0;
            ed_sum       <= '0;
            max_ed       <= '0;
        end else begin
            if (accept) begin
                sample_count <= sample_count + CNT_W'(1);
            end
            if (s1_valid) begin
                ed_sum    <= ed_sum + ACC_W'(s1_ed);
                err_count <= err_count + CNT_W'(s1_nz);
                if (s1_ed > max_ed) begin
                    max_ed <= s1_ed;
                end
            end
        end
    end

`ifdef AXPPA_ERR_MON_SQ_EN
    localparam int SQ_W = 2*(WIDTH+1) + CNT_W;

    logic [2*(WIDTH+1)-1:0] sq_term;

    assign sq_term = {{(WIDTH+1){1'b0}}, s1_ed} * {{(WIDTH+1){1'b0}}, s1_ed};

    // Square accumulates in step with the other stage-2 metrics.
    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            sq_sum <= '0;
        end else if (s1_valid) begin
            sq_sum <= sq_sum + SQ_W'(sq_term);
        end
    end
`endif

endmodule

// File: tb/tb_axppa_error_monitor.sv
// Self-checking bench for axppa_error_monitor. Sums are driven and outputs
// observed on the falling clock edge; expected metrics come from a plain
// arithmetic model over the queue of pairs fed to each window.
// Compile with AXPPA_ERR_MON_SQ_EN defined to also check sq_sum.
module tb_axppa_error_monitor;

    localparam int WIDTH = 16;
    localparam int CNT_W = 20;
    localparam int ACC_W = WIDTH + 1 + CNT_W;
    localparam int SQ_W  = 2*(WIDTH+1) + CNT_W;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] window;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] err_count;
    logic [ACC_W-1:0] ed_sum;
    logic [WIDTH:0]   max_ed;
    logic [CNT_W-1:0] sample_count;
`ifdef AXPPA_ERR_MON_SQ_EN
    logic [SQ_W-1:0]  sq_sum;
    logic [SQ_W-1:0]  exp_sq;
`endif

    axppa_error_monitor_if #(.WIDTH(WIDTH)) smp_if ();

    axppa_error_monitor #(
        .WIDTH        (WIDTH),
        .CNT_W        (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .window       (window),
        .smp          (smp_if),
        .busy         (busy),
        .done         (done),
        .err_count    (err_count),
        .ed_sum       (ed_sum),
        .max_ed       (max_ed),
`ifdef AXPPA_ERR_MON_SQ_EN
        .sq_sum       (sq_sum),
`endif
        .sample_count (sample_count)
    );

    always #5 clk = ~clk;

    int vectors;
    int miscompares;

    logic [WIDTH:0]   q_exact[$];
    logic [WIDTH:0]   q_approx[$];
    logic [CNT_W-1:0] exp_err;
    logic [CNT_W-1:0] exp_cnt;
    logic [ACC_W-1:0] exp_sum;
    logic [WIDTH:0]   exp_max;

    int   lat;
    int   ready_miss;
    logic ready_after;

    // Reference metrics straight from the definitions of ER/MED/max.
    task automatic run_model(input int win);
        longint unsigned x, y, e, s, sq, mx;
        int errs;
        s = 0; sq = 0; mx = 0; errs = 0;
        for (int i = 0; i < win; i++) begin
            x = q_exact[i];
            y = q_approx[i];
            e = (x >= y) ? (x - y) : (y - x);
            s  += e;
            sq += e * e;
            if (e != 0) errs++;
            if (e > mx) mx = e;
        end
        exp_err = CNT_W'(errs);
        exp_cnt = CNT_W'(win);
        exp_sum = ACC_W'(s);
        exp_max = (WIDTH+1)'(mx);
`ifdef AXPPA_ERR_MON_SQ_EN
        exp_sq  = SQ_W'(sq);
`else
        if (sq == 0) exp_err = exp_err;
`endif
    endtask

    task automatic load_random(input int n);
        logic [WIDTH:0] x, y;
        q_exact.delete();
        q_approx.delete();
        for (int i = 0; i < n; i++) begin
            x = (WIDTH+1)'($urandom);
            case ($urandom_range(0, 2))
                0:       y = x;
                1:       y = (WIDTH+1)'($urandom);
                default: y = x ^ (WIDTH+1)'($urandom_range(1, 255));
            endcase
            q_exact.push_back(x);
            q_approx.push_back(y);
        end
    endtask

    // Runs one window from IDLE; returns at the negedge where done is seen.
    // gap_mode: 0 back-to-back, 1 alternating, 2 random gaps.
    // noise: hold start high (with window=1) through RUN, DRAIN and DONE.
    task automatic drive_window(input int win, input int gap_mode, input bit noise,
                                output int lat_o, output int miss_o, output logic after_o);
        int accepted;
        int cyc;
        bit v;
        accepted = 0; cyc = 0; lat_o = -1; miss_o = 0;
        start  = 1'b1;
        window = CNT_W'(win);
        @(negedge clk);
        start  = noise;
        window = noise ? CNT_W'(1) : CNT_W'(win);
        while (accepted < win && cyc < 4*win + 20) begin
            case (gap_mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            smp_if.in_valid = v;
            if (v) begin
                smp_if.exact_sum  = q_exact[accepted];
                smp_if.approx_sum = q_approx[accepted];
                if (smp_if.in_ready !== 1'b1) miss_o++;
                accepted++;
            end else begin
                smp_if.exact_sum  = (WIDTH+1)'($urandom);
                smp_if.approx_sum = (WIDTH+1)'($urandom);
            end
            cyc++;
            @(negedge clk);
        end
        after_o = smp_if.in_ready;
        // Junk presented while the monitor no longer accepts samples.
        smp_if.in_valid   = 1'b1;
        smp_if.exact_sum  = (WIDTH+1)'($urandom);
        smp_if.approx_sum = (WIDTH+1)'($urandom);
        for (int i = 1; i <= 20; i++) begin
            start = noise;
            if (done === 1'b1) begin
                lat_o = i;
                break;
            end
            @(negedge clk);
        end
        smp_if.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; window = CNT_W'(5);
        smp_if.in_valid = 1'b1;
        repeat (3) begin
            smp_if.exact_sum  = (WIDTH+1)'($urandom);
            smp_if.approx_sum = (WIDTH+1)'($urandom);
            @(negedge clk);
        end
        vectors++; if (smp_if.in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_in_ready: got %b expected 0", smp_if.in_ready); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_busy: got %b expected 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_done: got %b expected 0", done); end
        vectors++; if (err_count !== '0) begin miscompares++; $display("[TB] FAIL rst_err_count: got %0d expected 0", err_count); end
        vectors++; if (ed_sum !== '0) begin miscompares++; $display("[TB] FAIL rst_ed_sum: got %0d expected 0", ed_sum); end
        vectors++; if (max_ed !== '0) begin miscompares++; $display("[TB] FAIL rst_max_ed: got %0d expected 0", max_ed); end
        vectors++; if (sample_count !== '0) begin miscompares++; $display("[TB] FAIL rst_sample_count: got %0d expected 0", sample_count); end
`ifdef AXPPA_ERR_MON_SQ_EN
        vectors++; if (sq_sum !== '0) begin miscompares++; $display("[TB] FAIL rst_sq_sum: got %0d expected 0", sq_sum); end
`endif
        rst = 1'b0; start = 1'b0; smp_if.in_valid = 1'b0;
        @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_directed();
        int ex[4];
        int ap[4];
        ex = '{100, 50, 7, 131071};
        ap = '{96, 50, 9, 0};
        q_exact.delete(); q_approx.delete();
        for (int i = 0; i < 4; i++) begin
            q_exact.push_back((WIDTH+1)'(ex[i]));
            q_approx.push_back((WIDTH+1)'(ap[i]));
        end
        drive_window(4, 0, 1'b0, lat, ready_miss, ready_after);
        vectors++; if (lat !== 3) begin miscompares++; $display("[TB] FAIL dir_done_latency: got %0d expected 3", lat); end
        vectors++; if (ready_miss !== 0) begin miscompares++; $display("[TB] FAIL dir_in_ready: got %0d misses expected 0", ready_miss); end
        vectors++; if (ready_after !== 1'b0) begin miscompares++; $display("[TB] FAIL dir_ready_fall: got %b expected 0", ready_after); end
        vectors++; if (err_count !== CNT_W'(3)) begin miscompares++; $display("[TB] FAIL dir_err_count: got %0d expected 3", err_count); end
        vectors++; if (ed_sum !== ACC_W'(131077)) begin miscompares++; $display("[TB] FAIL dir_ed_sum: got %0d expected 131077", ed_sum); end
        vectors++; if (max_ed !== 17'd131071) begin miscompares++; $display("[TB] FAIL dir_max_ed: got %0d expected 131071", max_ed); end
        vectors++; if (sample_count !== CNT_W'(4)) begin miscompares++; $display("[TB] FAIL dir_sample_count: got %0d expected 4", sample_count); end
`ifdef AXPPA_ERR_MON_SQ_EN
        vectors++; if (sq_sum !== SQ_W'(64'd17179607061)) begin miscompares++; $display("[TB] FAIL dir_sq_sum: got %0d expected 17179607061", sq_sum); end
`endif
        @(negedge clk);
        vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL dir_done_pulse: got %b expected 0", done); end
    endtask

    task automatic test_gaps();
        load_random(3);
        run_model(3);
        drive_window(3, 1, 1'b0, lat, ready_miss, ready_after);
        vectors++; if (lat !== 3) begin miscompares++; $display("[TB] FAIL gap_done_latency: got %0d expected 3", lat); end
        vectors++; if (ready_miss !== 0) begin miscompares++; $display("[TB] FAIL gap_in_ready: got %0d misses expected 0", ready_miss); end
        vectors++; if (sample_count !== exp_cnt) begin miscompares++; $display("[TB] FAIL gap_sample_count: got %0d expected %0d", sample_count, exp_cnt); end
        vectors++; if (err_count !== exp_err) begin miscompares++; $display("[TB] FAIL gap_err_count: got %0d expected %0d", err_count, exp_err); end
        vectors++; if (ed_sum !== exp_sum) begin miscompares++; $display("[TB] FAIL gap_ed_sum: got %0d expected %0d", ed_sum, exp_sum); end
        vectors++; if (max_ed !== exp_max) begin miscompares++; $display("[TB] FAIL gap_max_ed: got %0d expected %0d", max_ed, exp_max); end
`ifdef AXPPA_ERR_MON_SQ_EN
        vectors++; if (sq_sum !== exp_sq) begin miscompares++; $display("[TB] FAIL gap_sq_sum: got %0d expected %0d", sq_sum, exp_sq); end
`endif
        @(negedge clk);
    endtask

    task automatic test_window_zero();
        start = 1'b1; window = '0;
        @(negedge clk);
        start = 1'b0;
        vectors++; if (done !== 1'b1) begin miscompares++; $display("[TB] FAIL w0_done: got %b expected 1", done); end
        vectors++; if (smp_if.in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL w0_in_ready: got %b expected 0", smp_if.in_ready); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL w0_busy: got %b expected 0", busy); end
        vectors++; if (err_count !== '0) begin miscompares++; $display("[TB] FAIL w0_err_count: got %0d expected 0", err_count); end
        vectors++; if (ed_sum !== '0) begin miscompares++; $display("[TB] FAIL w0_ed_sum: got %0d expected 0", ed_sum); end
        vectors++; if (max_ed !== '0) begin miscompares++; $display("[TB] FAIL w0_max_ed: got %0d expected 0", max_ed); end
        vectors++; if (sample_count !== '0) begin miscompares++; $display("[TB] FAIL w0_sample_count: got %0d expected 0", sample_count); end
        @(negedge clk);
        vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL w0_done_pulse: got %b expected 0", done); end
        vectors++; if (smp_if.in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL w0_in_ready_after: got %b expected 0", smp_if.in_ready); end
    endtask

    task automatic test_reset_abort();
        load_random(8);
        start = 1'b1; window = CNT_W'(8);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            smp_if.in_valid   = 1'b1;
            smp_if.exact_sum  = q_exact[i] | 17'h1;
            smp_if.approx_sum = q_exact[i] & 17'h1FFFE;
            @(negedge clk);
        end
        smp_if.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
        vectors++; if (smp_if.in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_in_ready: got %b expected 0", smp_if.in_ready); end
        vectors++; if (sample_count !== '0) begin miscompares++; $display("[TB] FAIL abort_sample_count: got %0d expected 0", sample_count); end
        vectors++; if (ed_sum !== '0) begin miscompares++; $display("[TB] FAIL abort_ed_sum: got %0d expected 0", ed_sum); end
        vectors++; if (err_count !== '0) begin miscompares++; $display("[TB] FAIL abort_err_count: got %0d expected 0", err_count); end
        q_exact.delete(); q_approx.delete();
        q_exact.push_back(17'd5);
        q_approx.push_back(17'd2);
        drive_window(1, 0, 1'b0, lat, ready_miss, ready_after);
        vectors++; if (lat !== 3) begin miscompares++; $display("[TB] FAIL abort_new_latency: got %0d expected 3", lat); end
        vectors++; if (ed_sum !== ACC_W'(3)) begin miscompares++; $display("[TB] FAIL abort_new_ed_sum: got %0d expected 3", ed_sum); end
        vectors++; if (err_count !== CNT_W'(1)) begin miscompares++; $display("[TB] FAIL abort_new_err_count: got %0d expected 1", err_count); end
        vectors++; if (max_ed !== 17'd3) begin miscompares++; $display("[TB] FAIL abort_new_max_ed: got %0d expected 3", max_ed); end
        vectors++; if (sample_count !== CNT_W'(1)) begin miscompares++; $display("[TB] FAIL abort_new_sample_count: got %0d expected 1", sample_count); end
        @(negedge clk);
    endtask

    task automatic test_ignored_start();
        load_random(5);
        q_approx[0] = q_exact[0] ^ 17'h10;
        run_model(5);
        drive_window(5, 2, 1'b1, lat, ready_miss, ready_after);
        vectors++; if (lat !== 3) begin miscompares++; $display("[TB] FAIL ign_done_latency: got %0d expected 3", lat); end
        vectors++; if (ready_miss !== 0) begin miscompares++; $display("[TB] FAIL ign_in_ready: got %0d misses expected 0", ready_miss); end
        vectors++; if (sample_count !== exp_cnt) begin miscompares++; $display("[TB] FAIL ign_sample_count: got %0d expected %0d", sample_count, exp_cnt); end
        vectors++; if (ed_sum !== exp_sum) begin miscompares++; $display("[TB] FAIL ign_ed_sum: got %0d expected %0d", ed_sum, exp_sum); end
        @(negedge clk);
        start = 1'b0;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL ign_done_start_busy: got %b expected 0", busy); end
        @(negedge clk);
        vectors++; if (sample_count !== exp_cnt) begin miscompares++; $display("[TB] FAIL ign_hold_sample_count: got %0d expected %0d", sample_count, exp_cnt); end
        vectors++; if (err_count !== exp_err) begin miscompares++; $display("[TB] FAIL ign_hold_err_count: got %0d expected %0d", err_count, exp_err); end
        vectors++; if (ed_sum !== exp_sum) begin miscompares++; $display("[TB] FAIL ign_hold_ed_sum: got %0d expected %0d", ed_sum, exp_sum); end
        vectors++; if (max_ed !== exp_max) begin miscompares++; $display("[TB] FAIL ign_hold_max_ed: got %0d expected %0d", max_ed, exp_max); end
    endtask

    task automatic test_back_to_back();
        int win;
        for (int w = 0; w < 4; w++) begin
            win = $urandom_range(1, 10);
            load_random(win);
            run_model(win);
            drive_window(win, 2, 1'b0, lat, ready_miss, ready_after);
            vectors++; if (lat !== 3) begin miscompares++; $display("[TB] FAIL b2b_done_latency: got %0d expected 3", lat); end
            vectors++; if (ready_miss !== 0) begin miscompares++; $display("[TB] FAIL b2b_in_ready: got %0d misses expected 0", ready_miss); end
            vectors++; if (sample_count !== exp_cnt) begin miscompares++; $display("[TB] FAIL b2b_sample_count: got %0d expected %0d", sample_count, exp_cnt); end
            vectors++; if (err_count !== exp_err) begin miscompares++; $display("[TB] FAIL b2b_err_count: got %0d expected %0d", err_count, exp_err); end
            vectors++; if (ed_sum !== exp_sum) begin miscompares++; $display("[TB] FAIL b2b_ed_sum: got %0d expected %0d", ed_sum, exp_sum); end
            vectors++; if (max_ed !== exp_max) begin miscompares++; $display("[TB] FAIL b2b_max_ed: got %0d expected %0d", max_ed, exp_max); end
`ifdef AXPPA_ERR_MON_SQ_EN
            vectors++; if (sq_sum !== exp_sq) begin miscompares++; $display("[TB] FAIL b2b_sq_sum: got %0d expected %0d", sq_sum, exp_sq); end
`endif
            // Next start lands in the IDLE cycle right after done.
            @(negedge clk);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        start = 1'b0;
        window = '0;
        smp_if.in_valid   = 1'b0;
        smp_if.exact_sum  = '0;
        smp_if.approx_sum = '0;
        $display("[TB] starting axppa_error_monitor bench");
        test_reset();
        test_directed();
        test_gaps();
        test_window_zero();
        test_reset_abort();
        test_ignored_start();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
